// File: rtl/regression_pkg.sv
// -----------------------------------------------------------------------------
// regression_pkg
// Shared constants and types for the linear-regression front end.
//   ELEM_WIDTH   : width of one matrix element / entered value
//   NUM_SAMPLES  : (x, y) pairs per load
//   NUM_FEATURES : columns of the X design matrix (x and the intercept 1)
//   loader_state_t : sample_loader control states
//   err_code_t     : load rejection reasons reported on err_code
// -----------------------------------------------------------------------------
package regression_pkg;

  localparam int ELEM_WIDTH   = 14;
  localparam int NUM_SAMPLES  = 3;
  localparam int NUM_FEATURES = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    READY = 3'd3,
    ERROR = 3'd4
  } loader_state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_RANGE = 2'd1,
    ERR_COUNT = 2'd2,
    ERR_DEGEN = 2'd3
  } err_code_t;

endpackage

// File: rtl/sample_loader_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Brings an asynchronous button level into the clk domain through two flops
// and emits a one-cycle pulse on each rising edge of the synchronized level.
// The pulse is high in the cycle after the second flop first sees the level,
// so a consumer acts on it at the third clk edge after the raw level rises.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   i_level in  raw asynchronous level
//   o_pulse out one-cycle rising-edge pulse (decoded from flops only)
// -----------------------------------------------------------------------------
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Two-flop synchronizer followed by a history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_level;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/sample_loader.sv
// -----------------------------------------------------------------------------
// sample_loader
// Collects NUM_SAMPLES (x, y) pairs entered one value at a time (order x0, y0,
// x1, y1, ...), builds the X design matrix (x column plus a column of 1s) and
// the y vector, validates the load and raises ready for the regression chain.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   enter      in   raw button level, each rising edge commits data_in
//   input_done in   raw level, a rising edge ends the load
//   data_in    in   unsigned value to commit
//   x_data     out  X matrix row-major: element i*2 = x_i, element i*2+1 = 1
//   y_data     out  y vector: element i = y_i
//   ready      out  X and y are valid and checked
//   error      out  load rejected
//   err_code   out  0 none, 1 range, 2 count, 3 degenerate (all x equal)
//   sample_cnt out  values committed in the current load
//
// Build option: define SAMPLE_LOADER_RANGE_CHECK_EN to reject any committed
// value above MAX_VAL with err_code 1 (the value is not written).
// -----------------------------------------------------------------------------
module sample_loader #(
  parameter int ELEM_WIDTH  = regression_pkg::ELEM_WIDTH,
  parameter int NUM_SAMPLES = regression_pkg::NUM_SAMPLES,
  parameter int MAX_VAL     = 99
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   enter,
  input  logic                                   input_done,
  input  logic [ELEM_WIDTH-1:0]                  data_in,
  output logic [NUM_SAMPLES*2*ELEM_WIDTH-1:0]    x_data,
  output logic [NUM_SAMPLES*ELEM_WIDTH-1:0]      y_data,
  output logic                                   ready,
  output logic                                   error,
  output logic [1:0]                             err_code,
  output logic [$clog2(2*NUM_SAMPLES+1)-1:0]     sample_cnt
);

  import regression_pkg::*;

  localparam int NUM_VALS = 2 * NUM_SAMPLES;
  localparam int CNT_W    = $clog2(NUM_VALS + 1);
  localparam int XW       = NUM_SAMPLES * NUM_FEATURES * ELEM_WIDTH;
  localparam int YW       = NUM_SAMPLES * ELEM_WIDTH;
  localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(NUM_VALS);
  localparam logic [ELEM_WIDTH-1:0] ONE      = ELEM_WIDTH'(1);

`ifdef SAMPLE_LOADER_RANGE_CHECK_EN
  localparam logic RANGE_EN = 1'b1;
`else
  localparam logic RANGE_EN = 1'b0;
`endif

  loader_state_t    r_state;
  logic [XW-1:0]    r_x_data;
  logic [YW-1:0]    r_y_data;
  logic             r_ready;
  logic             r_error;
  err_code_t        r_err_code;
  logic [CNT_W-1:0] r_sample_cnt;

  logic             w_enter_p;
  logic             w_done_p;
  logic             w_range_bad;
  logic             w_fresh;
  logic [CNT_W-1:0] w_k;
  logic [XW-1:0]    w_x_base;
  logic [YW-1:0]    w_y_base;
  logic [XW-1:0]    w_x_commit;
  logic [YW-1:0]    w_y_commit;

  // True when every x_i matches x_0 over the full element width (det(XtX)=0).
  function automatic logic all_x_equal(input logic [XW-1:0] x);
    logic eq;
    eq = 1'b1;
    for (int i = 1; i < NUM_SAMPLES; i++) begin
      if (x[i*NUM_FEATURES*ELEM_WIDTH +: ELEM_WIDTH] != x[ELEM_WIDTH-1:0]) begin
        eq = 1'b0;
      end
    end
    return eq;
  endfunction

  sync_edge u_enter_sync (
    .clk     (clk),
    .rst_n   (rst),
    .i_level (enter),
    .o_pulse (w_enter_p)
  );

  sync_edge u_done_sync (
    .clk     (clk),
    .rst_n   (rst),
    .i_level (input_done),
    .o_pulse (w_done_p)
  );

  assign w_range_bad = RANGE_EN & (data_in > ELEM_WIDTH'(MAX_VAL));

  // Any commit outside LOAD starts a new load: arrays cleared, slot k = 0.
  assign w_fresh  = (r_state != LOAD);
  assign w_k      = w_fresh ? '0 : r_sample_cnt;
  assign w_x_base = w_fresh ? '0 : r_x_data;
  assign w_y_base = w_fresh ? '0 : r_y_data;

  // Arrays as they would look after committing data_in into slot w_k.
  always_comb begin
    w_x_commit = w_x_base;
    w_y_commit = w_y_base;
    if (w_k < FULL_CNT) begin
      if (w_k[0] == 1'b0) begin
        // Even slot: x_(k/2) lands at element k, its intercept at k+1.
        w_x_commit[32'(w_k) * ELEM_WIDTH +: ELEM_WIDTH]         = data_in;
        w_x_commit[(32'(w_k) + 32'd1) * ELEM_WIDTH +: ELEM_WIDTH] = ONE;
      end else begin
        w_y_commit[(32'(w_k) >> 1) * ELEM_WIDTH +: ELEM_WIDTH] = data_in;
      end
    end else begin
      w_x_commit = w_x_base;
      w_y_commit = w_y_base;
    end
  end

  // Load-control FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_x_data     <= '0;
      r_y_data     <= '0;
      r_ready      <= 1'b0;
      r_error      <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_sample_cnt <= '0;
    end else begin
      case (r_state)
        IDLE, READY, ERROR: begin
          if (w_enter_p) begin
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
            if (w_range_bad) begin
              r_x_data     <= '0;
              r_y_data     <= '0;
              r_sample_cnt <= '0;
              r_error      <= 1'b1;
              r_err_code   <= ERR_RANGE;
              r_state      <= ERROR;
            end else begin
              r_x_data     <= w_x_commit;
              r_y_data     <= w_y_commit;
              r_sample_cnt <= CNT_W'(1);
              r_state      <= LOAD;
            end
          end else if (w_done_p && (r_state == IDLE)) begin
            // Ending a load that never started is a count error.
            r_error    <= 1'b1;
            r_err_code <= ERR_COUNT;
            r_state    <= ERROR;
          end else begin
            r_state <= r_state;
          end
        end

        LOAD: begin
          if (w_enter_p) begin
            if (r_sample_cnt == FULL_CNT) begin
              r_error    <= 1'b1;
              r_err_code <= ERR_COUNT;
              r_state    <= ERROR;
            end else if (w_range_bad) begin
              r_error    <= 1'b1;
              r_err_code <= ERR_RANGE;
              r_state    <= ERROR;
            end else begin
              r_x_data     <= w_x_commit;
              r_y_data     <= w_y_commit;
              r_sample_cnt <= r_sample_cnt + CNT_W'(1);
              // A coincident done still checks, using the updated count.
              r_state      <= w_done_p ? CHECK : LOAD;
            end
          end else if (w_done_p) begin
            r_state <= CHECK;
          end else begin
            r_state <= LOAD;
          end
        end

        CHECK: begin
          if (r_sample_cnt != FULL_CNT) begin
            r_error    <= 1'b1;
            r_err_code <= ERR_COUNT;
            r_state    <= ERROR;
          end else if (all_x_equal(r_x_data)) begin
            r_error    <= 1'b1;
            r_err_code <= ERR_DEGEN;
            r_state    <= ERROR;
          end else begin
            r_ready <= 1'b1;
            r_state <= READY;
          end
        end

        default: begin
          r_state      <= IDLE;
          r_ready      <= 1'b0;
          r_error      <= 1'b0;
          r_err_code   <= ERR_NONE;
          r_sample_cnt <= '0;
        end
      endcase
    end
  end

  assign x_data     = r_x_data;
  assign y_data     = r_y_data;
  assign ready      = r_ready;
  assign error      = r_error;
  assign err_code   = r_err_code;
  assign sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_sample_loader.sv
// -----------------------------------------------------------------------------
// tb_sample_loader
// Table-driven and randomized bench for sample_loader. Expected arrays and
// flags come from a load-level reference model applying the loader's rules
// to the list of entered values.
// -----------------------------------------------------------------------------
module tb_sample_loader;

  localparam int EW = 14;
  localparam int NS = 3;

  logic              clk;
  logic              rst;
  logic              enter;
  logic              input_done;
  logic [EW-1:0]     data_in;
  logic [NS*2*EW-1:0] x_data;
  logic [NS*EW-1:0]  y_data;
  logic              ready;
  logic              error;
  logic [1:0]        err_code;
  logic [2:0]        sample_cnt;

  int n_pass;
  int n_total;

  sample_loader #(.ELEM_WIDTH(EW), .NUM_SAMPLES(NS), .MAX_VAL(99)) dut (
    .clk        (clk),
    .rst        (rst),
    .enter      (enter),
    .input_done (input_done),
    .data_in    (data_in),
    .x_data     (x_data),
    .y_data     (y_data),
    .ready      (ready),
    .error      (error),
    .err_code   (err_code),
    .sample_cnt (sample_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    int         v[8];
    logic       rdy;
    logic       er;
    logic [1:0] code;
    int         cnt;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Enter one value; optionally raise input_done in the same cycle.
  task automatic press(input int v, input bit with_done);
    @(negedge clk);
    data_in = EW'(v);
    enter = 1'b1;
    if (with_done) input_done = 1'b1;
    repeat (4) @(negedge clk);
    enter = 1'b0;
    input_done = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_done();
    @(negedge clk);
    input_done = 1'b1;
    repeat (4) @(negedge clk);
    input_done = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Reference: outcome of entering v[0..n-1] as one fresh load, then done.
  function automatic void model(input int v[8], input int n,
                                output logic [NS*2*EW-1:0] ex, output logic [NS*EW-1:0] ey,
                                output int cnt, output logic rdy, output logic er,
                                output logic [1:0] code);
    bit range_on;
    int i;
`ifdef SAMPLE_LOADER_RANGE_CHECK_EN
    range_on = 1'b1;
`else
    range_on = 1'b0;
`endif
    ex = '0; ey = '0; cnt = 0; rdy = 1'b0; er = 1'b0; code = 2'd0;
    for (int k = 0; k < n; k++) begin
      if (!er) begin
        if (range_on && v[k] > 99) begin
          er = 1'b1; code = 2'd1;
        end else if (cnt == 2*NS) begin
          er = 1'b1; code = 2'd2;
        end else begin
          i = cnt / 2;
          if (cnt % 2 == 0) begin
            ex[(i*2)*EW +: EW]   = EW'(v[k]);
            ex[(i*2+1)*EW +: EW] = EW'(1);
          end else begin
            ey[i*EW +: EW] = EW'(v[k]);
          end
          cnt++;
        end
      end
    end
    if (!er) begin
      if (cnt != 2*NS) begin
        er = 1'b1; code = 2'd2;
      end else if (EW'(v[0]) == EW'(v[2]) && EW'(v[2]) == EW'(v[4])) begin
        er = 1'b1; code = 2'd3;
      end else begin
        rdy = 1'b1;
      end
    end
  endfunction

  task automatic check_all(input string tag, input logic [NS*2*EW-1:0] ex,
                           input logic [NS*EW-1:0] ey, input int cnt, input logic rdy,
                           input logic er, input logic [1:0] code);
    check({tag, ".x_data"},     128'(x_data),     128'(ex));
    check({tag, ".y_data"},     128'(y_data),     128'(ey));
    check({tag, ".sample_cnt"}, 128'(sample_cnt), 128'(cnt));
    check({tag, ".ready"},      128'(ready),      128'(rdy));
    check({tag, ".error"},      128'(error),      128'(er));
    check({tag, ".err_code"},   128'(err_code),   128'(code));
  endtask

  initial begin
    logic [NS*2*EW-1:0] ex;
    logic [NS*EW-1:0]   ey;
    int cnt;
    logic rdy, er;
    logic [1:0] code;
    int rv[8];
    int rn;

    clk = 1'b0; rst = 1'b0; enter = 1'b0; input_done = 1'b0; data_in = '0;
    n_pass = 0; n_total = 0;

    tbl[0] = '{n: 6, v: '{8, 9, 5, 6, 2, 3, 0, 0}, rdy: 1'b1, er: 1'b0, code: 2'd0, cnt: 6};
    tbl[1] = '{n: 3, v: '{8, 9, 5, 0, 0, 0, 0, 0}, rdy: 1'b0, er: 1'b1, code: 2'd2, cnt: 3};
    tbl[2] = '{n: 6, v: '{4, 1, 4, 2, 4, 3, 0, 0}, rdy: 1'b0, er: 1'b1, code: 2'd3, cnt: 6};
    tbl[3] = '{n: 7, v: '{8, 9, 5, 6, 2, 3, 7, 0}, rdy: 1'b0, er: 1'b1, code: 2'd2, cnt: 6};
`ifdef SAMPLE_LOADER_RANGE_CHECK_EN
    tbl[4] = '{n: 1, v: '{150, 0, 0, 0, 0, 0, 0, 0}, rdy: 1'b0, er: 1'b1, code: 2'd1, cnt: 0};
`else
    tbl[4] = '{n: 6, v: '{150, 9, 5, 6, 2, 3, 0, 0}, rdy: 1'b1, er: 1'b0, code: 2'd0, cnt: 6};
`endif
    tbl[5] = '{n: 6, v: '{0, 0, 0, 0, 1, 0, 0, 0}, rdy: 1'b1, er: 1'b0, code: 2'd0, cnt: 6};

    // Reset state
    repeat (3) @(negedge clk);
    check_all("reset", '0, '0, 0, 1'b0, 1'b0, 2'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // input_done with nothing entered
    pulse_done();
    check("idle_done.error",    128'(error),    128'(1));
    check("idle_done.err_code", 128'(err_code), 128'(2));
    check("idle_done.ready",    128'(ready),    128'(0));

    // Table of whole loads
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < tbl[t].n; k++) press(tbl[t].v[k], 1'b0);
      pulse_done();
      model(tbl[t].v, tbl[t].n, ex, ey, cnt, rdy, er, code);
      check_all($sformatf("tbl%0d", t), ex, ey, tbl[t].cnt, tbl[t].rdy, tbl[t].er, tbl[t].code);
      if (t == 0) begin
        check("nominal.x_const", 128'(x_data),
              128'({14'd1, 14'd2, 14'd1, 14'd5, 14'd1, 14'd8}));
        check("nominal.y_const", 128'(y_data), 128'({14'd3, 14'd6, 14'd9}));
      end
    end

    // done -> ready latency: CHECK one edge after done_p, READY the next
    press(8, 1'b0); press(9, 1'b0); press(5, 1'b0);
    press(6, 1'b0); press(2, 1'b0); press(3, 1'b0);
    @(negedge clk);
    input_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("lat.ready_in_check", 128'(ready), 128'(0));
    @(negedge clk);
    check("lat.ready_after", 128'(ready), 128'(1));
    input_done = 1'b0;
    repeat (4) @(negedge clk);

    // New enter from READY: ready falls on the commit edge
    @(negedge clk);
    data_in = EW'(7);
    enter = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reload.ready_before", 128'(ready), 128'(1));
    @(negedge clk);
    check("reload.ready_commit", 128'(ready),      128'(0));
    check("reload.cnt_commit",   128'(sample_cnt), 128'(1));
    repeat (1) @(negedge clk);
    enter = 1'b0;
    repeat (4) @(negedge clk);

    // Continue that load; sixth value arrives together with input_done
    press(10, 1'b0); press(20, 1'b0); press(30, 1'b0); press(40, 1'b0);
    press(50, 1'b1);
    rv = '{7, 10, 20, 30, 40, 50, 0, 0};
    model(rv, 6, ex, ey, cnt, rdy, er, code);
    check_all("simul", ex, ey, cnt, rdy, er, code);

    // Randomized loads against the reference model
    for (int r = 0; r < 12; r++) begin
      rn = int'($urandom_range(5, 7));
      for (int k = 0; k < 8; k++) rv[k] = int'($urandom_range(0, 99));
      if ($urandom_range(0, 3) == 0) begin
        rv[2] = rv[0];
        rv[4] = rv[0];
      end
      for (int k = 0; k < rn; k++) press(rv[k], 1'b0);
      pulse_done();
      model(rv, rn, ex, ey, cnt, rdy, er, code);
      check_all($sformatf("rand%0d", r), ex, ey, cnt, rdy, er, code);
    end

    // Reset in the middle of a load discards everything
    press(11, 1'b0); press(12, 1'b0); press(13, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all("midreset", '0, '0, 0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    pulse_done();
    check("midreset.idle_err",  128'(error),    128'(1));
    check("midreset.idle_code", 128'(err_code), 128'(2));
    check("midreset.idle_cnt",  128'(sample_cnt), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
